// File: rtl/mem_port_pkg.sv
// Shared encodings and defaults for the CPU-stage memory port server.
// Grant codes double as the externally visible grant_id value.
package mem_port_pkg;

    localparam int ADDR_W_DEF       = 16;
    localparam int DATA_W_DEF       = 8;
    localparam int STARVE_LIMIT_DEF = 4;

    // Bit positions of the one-hot winner vector from the priority select
    localparam int GNT_BIT_FETCH  = 0;
    localparam int GNT_BIT_STAGE3 = 1;
    localparam int GNT_BIT_STAGE5 = 2;

    typedef enum logic [1:0] {
        GRANT_NONE   = 2'd0,
        GRANT_FETCH  = 2'd1,
        GRANT_STAGE3 = 2'd2,
        GRANT_STAGE5 = 2'd3
    } grant_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LATCH = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_port_server_if.sv
// Request/response bundle between the three CPU stages, the server and its RAM.
// The slave modport is the server end; master is the stages plus RAM.
interface mem_port_server_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              stage12_read;
    logic              stage12_read_ready;
    logic [ADDR_W-1:0] stage12_read_address;
    logic [DATA_W-1:0] stage12_read_data_out;

    logic              stage3_read;
    logic              stage3_read_ready;
    logic [ADDR_W-1:0] stage3_read_address;
    logic [DATA_W-1:0] stage3_read_data_out;

    logic              stage5_save;
    logic              stage5_save_ready;
    logic [ADDR_W-1:0] stage5_save_address;
    logic [DATA_W-1:0] stage5_save_data_in;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        grant_id;

    modport slave (
        input  stage12_read, stage12_read_address,
        output stage12_read_ready, stage12_read_data_out,
        input  stage3_read, stage3_read_address,
        output stage3_read_ready, stage3_read_data_out,
        input  stage5_save, stage5_save_address, stage5_save_data_in,
        output stage5_save_ready,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output grant_id
    );

    modport master (
        output stage12_read, stage12_read_address,
        input  stage12_read_ready, stage12_read_data_out,
        output stage3_read, stage3_read_address,
        input  stage3_read_ready, stage3_read_data_out,
        output stage5_save, stage5_save_address, stage5_save_data_in,
        input  stage5_save_ready,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  grant_id
    );
endinterface

// File: rtl/mem_port_priority.sv
// Combinational winner select: stage5 > stage3 > fetch, with fetch forced to
// the front when the parent's starvation guard fires.
module mem_port_priority
    import mem_port_pkg::*;
(
    input  logic       req_fetch_i,
    input  logic       req_stage3_i,
    input  logic       req_stage5_i,
    input  logic       starve_force_i,
    output logic [2:0] grant_o
);

    always_comb begin
        grant_o = '0;
        // The force only matters if fetch is actually asking
        if (starve_force_i && req_fetch_i) begin
            grant_o[GNT_BIT_FETCH] = 1'b1;
        end else if (req_stage5_i) begin
            grant_o[GNT_BIT_STAGE5] = 1'b1;
        end else if (req_stage3_i) begin
            grant_o[GNT_BIT_STAGE3] = 1'b1;
        end else if (req_fetch_i) begin
            grant_o[GNT_BIT_FETCH] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_server.sv
// Server end of the four-phase req/ready handshake for fetch, data read and
// save ports, serialising one access at a time onto a 1-cycle-latency RAM.
module mem_port_server
    import mem_port_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic               ram_clk,
    input  logic               rst,
    mem_port_server_if.slave   bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              rdy12_q, rdy12_d;
    logic              rdy3_q, rdy3_d;
    logic              rdy5_q, rdy5_d;
    logic [DATA_W-1:0] dout12_q, dout12_d;
    logic [DATA_W-1:0] dout3_q, dout3_d;
    logic [CNT_W-1:0]  starve_q, starve_d;

    logic              starve_force;
    logic [2:0]        win;
    logic              granted_req;

    assign starve_force = (starve_q == STARVE_MAX);

    mem_port_priority u_prio (
        .req_fetch_i    (bus.stage12_read),
        .req_stage3_i   (bus.stage3_read),
        .req_stage5_i   (bus.stage5_save),
        .starve_force_i (starve_force),
        .grant_o        (win)
    );

    always_comb begin
        case (grant_q)
            GRANT_FETCH:  granted_req = bus.stage12_read;
            GRANT_STAGE3: granted_req = bus.stage3_read;
            GRANT_STAGE5: granted_req = bus.stage5_save;
            default:      granted_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rdy12_d  = rdy12_q;
        rdy3_d   = rdy3_q;
        rdy5_d   = rdy5_q;
        dout12_d = dout12_q;
        dout3_d  = dout3_q;
        starve_d = starve_q;

        case (state_q)
            IDLE: begin
                if (win[GNT_BIT_STAGE5]) begin
                    grant_d = GRANT_STAGE5;
                    addr_d  = bus.stage5_save_address;
                    wdata_d = bus.stage5_save_data_in;
                end else if (win[GNT_BIT_STAGE3]) begin
                    grant_d = GRANT_STAGE3;
                    addr_d  = bus.stage3_read_address;
                end else if (win[GNT_BIT_FETCH]) begin
                    grant_d = GRANT_FETCH;
                    addr_d  = bus.stage12_read_address;
                end
                if (|win) begin
                    we_d    = win[GNT_BIT_STAGE5];
                    state_d = ISSUE;
                end
                // Count foreign grants only while fetch is left waiting
                if (!bus.stage12_read || win[GNT_BIT_FETCH]) begin
                    starve_d = '0;
                end else if ((win[GNT_BIT_STAGE3] || win[GNT_BIT_STAGE5]) &&
                             (starve_q != STARVE_MAX)) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            ISSUE: begin
                we_d    = 1'b0;
                state_d = LATCH;
            end
            LATCH: begin
                case (grant_q)
                    GRANT_FETCH: begin
                        dout12_d = bus.mem_rdata;
                        rdy12_d  = 1'b1;
                    end
                    GRANT_STAGE3: begin
                        dout3_d = bus.mem_rdata;
                        rdy3_d  = 1'b1;
                    end
                    GRANT_STAGE5: rdy5_d = 1'b1;
                    default: ;
                endcase
                state_d = RESP;
            end
            RESP: begin
                if (!granted_req) begin
                    rdy12_d = 1'b0;
                    rdy3_d  = 1'b0;
                    rdy5_d  = 1'b0;
                    grant_d = GRANT_NONE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= GRANT_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdy12_q  <= 1'b0;
            rdy3_q   <= 1'b0;
            rdy5_q   <= 1'b0;
            dout12_q <= '0;
            dout3_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdy12_q  <= rdy12_d;
            rdy3_q   <= rdy3_d;
            rdy5_q   <= rdy5_d;
            dout12_q <= dout12_d;
            dout3_q  <= dout3_d;
            starve_q <= starve_d;
        end
    end

    assign bus.stage12_read_ready    = rdy12_q;
    assign bus.stage12_read_data_out = dout12_q;
    assign bus.stage3_read_ready     = rdy3_q;
    assign bus.stage3_read_data_out  = dout3_q;
    assign bus.stage5_save_ready     = rdy5_q;
    assign bus.mem_we                = we_q;
    assign bus.mem_addr              = addr_q;
    assign bus.mem_wdata             = wdata_q;
    assign bus.grant_id              = grant_q;

endmodule

// File: tb/tb_mem_port_server.sv
// Randomised requester bench for mem_port_server with a transaction-level
// reference model, plus directed reset/latency/priority/starvation scenarios.
module tb_mem_port_server;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int SL = 2;

    logic ram_clk;
    logic rst = 1'b0;

    mem_port_server_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_server #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .ram_clk (ram_clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial begin
        ram_clk = 1'b0;
        forever #5 ram_clk = ~ram_clk;
    end

    // Requesters: index 0 fetch, 1 stage3 read, 2 stage5 save
    logic          req_a [3];
    logic [AW-1:0] adr_a [3];
    logic [DW-1:0] sdata;
    int            cool  [3];

    assign bus.stage12_read         = req_a[0];
    assign bus.stage12_read_address = adr_a[0];
    assign bus.stage3_read          = req_a[1];
    assign bus.stage3_read_address  = adr_a[1];
    assign bus.stage5_save          = req_a[2];
    assign bus.stage5_save_address  = adr_a[2];
    assign bus.stage5_save_data_in  = sdata;

    // Environment RAM: registered read, write on mem_we
    logic [DW-1:0] ram [65536];
    logic [DW-1:0] rdata_q;
    assign bus.mem_rdata = rdata_q;
    always @(posedge ram_clk) begin
        rdata_q <= ram[bus.mem_addr];
        if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: one transaction at a time, timed in edges since grant
    logic [DW-1:0] mm [65536];
    bit            m_busy;
    int            m_age;
    int            m_gnt;
    int            mw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_we;
    bit            m_rdy [3];
    logic [DW-1:0] m_dout [2];
    int            m_starve;

    always @(posedge ram_clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_age = 0; m_gnt = 0; m_we = 0; m_starve = 0;
            m_addr = '0; m_wdata = '0;
            for (int i = 0; i < 3; i++) m_rdy[i] = 0;
            m_dout[0] = '0; m_dout[1] = '0;
        end else if (!m_busy) begin
            mw = -1;
            if (m_starve == SL && req_a[0]) mw = 0;
            else if (req_a[2]) mw = 2;
            else if (req_a[1]) mw = 1;
            else if (req_a[0]) mw = 0;
            if (mw >= 0) begin
                m_busy = 1; m_age = 0; m_gnt = mw;
                m_addr = adr_a[mw];
                m_we   = (mw == 2);
                if (mw == 2) m_wdata = sdata;
                if (mw == 0) m_starve = 0;
                else if (req_a[0] && m_starve < SL) m_starve++;
            end
            if (!req_a[0]) m_starve = 0;
        end else begin
            m_age++;
            if (m_age == 1) begin
                if (m_we) mm[m_addr] = m_wdata;
                m_we = 0;
            end else if (m_age == 2) begin
                m_rdy[m_gnt] = 1;
                if (m_gnt < 2) m_dout[m_gnt] = mm[m_addr];
            end else if (!req_a[m_gnt]) begin
                m_rdy[m_gnt] = 0;
                m_busy = 0;
            end
        end
    end

    always @(negedge ram_clk) begin
        chk("grant_id", 32'(bus.grant_id), 32'(m_busy ? m_gnt + 1 : 0));
        chk("rdy12", 32'(bus.stage12_read_ready), 32'(m_rdy[0]));
        chk("rdy3", 32'(bus.stage3_read_ready), 32'(m_rdy[1]));
        chk("rdy5", 32'(bus.stage5_save_ready), 32'(m_rdy[2]));
        chk("dout12", 32'(bus.stage12_read_data_out), 32'(m_dout[0]));
        chk("dout3", 32'(bus.stage3_read_data_out), 32'(m_dout[1]));
        chk("mem_we", 32'(bus.mem_we), 32'(m_we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        if (m_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
    end

    function automatic bit rdy(input int p);
        case (p)
            0:       return bus.stage12_read_ready;
            1:       return bus.stage3_read_ready;
            default: return bus.stage5_save_ready;
        endcase
    endfunction

    task automatic set_mem(input logic [AW-1:0] a, input logic [DW-1:0] v);
        ram[a] = v;
        mm[a]  = v;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge ram_clk);
            ok = (bus.grant_id == 2'd0) && !rdy(0) && !rdy(1) && !rdy(2);
        end
        chk("idle reached", 32'(ok), 32'd1);
    endtask

    int gseq [$];

    // Four-phase requesters; optionally re-raise stage5/stage3 right after completion
    task automatic run_grants(input bit re5, input bit re3, input int budget);
        logic [1:0] last;
        bit done;
        gseq.delete();
        last = 2'd0;
        done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge ram_clk);
            if (bus.grant_id != 2'd0 && bus.grant_id != last) gseq.push_back(int'(bus.grant_id));
            last = bus.grant_id;
            for (int p = 0; p < 3; p++) begin
                if (req_a[p] && rdy(p)) req_a[p] = 1'b0;
                else if (!req_a[p] && !rdy(p) && gseq.size() < 3 &&
                         ((p == 2 && re5) || (p == 1 && re3))) req_a[p] = 1'b1;
            end
            done = (gseq.size() >= 3) && !req_a[0] && !req_a[1] && !req_a[2] &&
                   (bus.grant_id == 2'd0);
        end
        chk("grant sequence completed", 32'(done), 32'd1);
    endtask

    function automatic int gs(input int i);
        return (gseq.size() > i) ? gseq[i] : -1;
    endfunction

    task automatic drive_port(input int p);
        if (cool[p] > 0) begin
            cool[p]--;
        end else if (req_a[p] && rdy(p)) begin
            req_a[p] = 1'b0;
        end else if (req_a[p] && $urandom_range(0, 19) == 0) begin
            req_a[p] = 1'b0;
            cool[p]  = 8;
        end else if (!req_a[p] && !rdy(p) && $urandom_range(0, 3) == 0) begin
            req_a[p] = 1'b1;
            adr_a[p] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31)) : AW'($urandom);
            if (p == 2) sdata = DW'($urandom);
        end
    endtask

    initial begin
        for (int p = 0; p < 3; p++) begin
            req_a[p] = 1'b0; adr_a[p] = '0; cool[p] = 0;
        end
        sdata = '0;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = DW'($urandom);
            mm[i]  = ram[i];
        end

        // Reset held with every request pending
        req_a[0] = 1'b1; adr_a[0] = 16'h0070;
        req_a[1] = 1'b1; adr_a[1] = 16'h0060;
        req_a[2] = 1'b1; adr_a[2] = 16'h0050; sdata = 8'h11;
        repeat (3) @(negedge ram_clk);
        chk("reset grant_id", 32'(bus.grant_id), 32'd0);
        chk("reset mem_we", 32'(bus.mem_we), 32'd0);
        chk("reset mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("reset rdy12", 32'(bus.stage12_read_ready), 32'd0);
        chk("reset rdy5", 32'(bus.stage5_save_ready), 32'd0);
        chk("reset dout3", 32'(bus.stage3_read_data_out), 32'd0);
        @(posedge ram_clk);
        #2 rst = 1'b1;
        run_grants(0, 0, 80);
        chk("post-reset first grant", 32'(gs(0)), 32'd3);
        chk("post-reset save committed", 32'(ram[16'h0050]), 32'h11);

        // Single fetch latency and data
        set_mem(16'h0010, 8'hA5);
        @(negedge ram_clk);
        req_a[0] = 1'b1; adr_a[0] = 16'h0010;
        @(negedge ram_clk);
        @(negedge ram_clk);
        chk("fetch ready not early", 32'(bus.stage12_read_ready), 32'd0);
        @(negedge ram_clk);
        chk("fetch ready", 32'(bus.stage12_read_ready), 32'd1);
        chk("fetch data", 32'(bus.stage12_read_data_out), 32'hA5);
        req_a[0] = 1'b0;
        @(negedge ram_clk);
        chk("fetch ready drop", 32'(bus.stage12_read_ready), 32'd0);
        wait_idle(20);

        // Simultaneous save, read of the same address, and fetch
        set_mem(16'h0020, 8'h00);
        @(negedge ram_clk);
        req_a[2] = 1'b1; adr_a[2] = 16'h0020; sdata = 8'h5C;
        req_a[1] = 1'b1; adr_a[1] = 16'h0020;
        req_a[0] = 1'b1; adr_a[0] = 16'h0000;
        run_grants(0, 0, 80);
        chk("simul grant 1", 32'(gs(0)), 32'd3);
        chk("simul grant 2", 32'(gs(1)), 32'd2);
        chk("simul grant 3", 32'(gs(2)), 32'd1);
        chk("simul read-after-save", 32'(bus.stage3_read_data_out), 32'h5C);
        chk("model mem 0x20", 32'(mm[16'h0020]), 32'h5C);

        // Starvation: stage5/stage3 keep coming back while fetch waits
        @(negedge ram_clk);
        req_a[2] = 1'b1; adr_a[2] = 16'h0021; sdata = 8'h33;
        req_a[1] = 1'b1; adr_a[1] = 16'h0022;
        req_a[0] = 1'b1; adr_a[0] = 16'h0023;
        run_grants(1, 1, 200);
        chk("starve grant 1", 32'(gs(0)), 32'd3);
        chk("starve grant 2", 32'(gs(1)), 32'd3);
        chk("starve grant 3 fetch", 32'(gs(2)), 32'd1);

        // Reset during the issue cycle of a save
        set_mem(16'h0030, 8'h12);
        @(negedge ram_clk);
        req_a[2] = 1'b1; adr_a[2] = 16'h0030; sdata = 8'h77;
        @(posedge ram_clk);
        #1 chk("midrst grant", 32'(bus.grant_id), 32'd3);
        chk("midrst we before", 32'(bus.mem_we), 32'd1);
        #1 rst = 1'b0;
        #1 chk("midrst we drop", 32'(bus.mem_we), 32'd0);
        chk("midrst ready", 32'(bus.stage5_save_ready), 32'd0);
        req_a[2] = 1'b0;
        @(posedge ram_clk);
        @(posedge ram_clk);
        #2 rst = 1'b1;
        chk("midrst ram untouched", 32'(ram[16'h0030]), 32'h12);
        chk("midrst model untouched", 32'(mm[16'h0030]), 32'h12);

        // Request dropped during LATCH
        set_mem(16'h0040, 8'h9E);
        @(negedge ram_clk);
        req_a[1] = 1'b1; adr_a[1] = 16'h0040;
        @(negedge ram_clk);
        @(negedge ram_clk);
        req_a[1] = 1'b0;
        @(negedge ram_clk);
        chk("early drop ready", 32'(bus.stage3_read_ready), 32'd1);
        chk("early drop data", 32'(bus.stage3_read_data_out), 32'h9E);
        @(negedge ram_clk);
        chk("early drop ready low", 32'(bus.stage3_read_ready), 32'd0);
        chk("early drop idle", 32'(bus.grant_id), 32'd0);
        @(negedge ram_clk);
        chk("early drop stays low", 32'(bus.stage3_read_ready), 32'd0);

        // Randomised traffic against the model
        for (int c = 0; c < 2000; c++) begin
            @(negedge ram_clk);
            for (int p = 0; p < 3; p++) drive_port(p);
        end
        for (int p = 0; p < 3; p++) req_a[p] = 1'b0;
        wait_idle(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
